// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream path.
// Contents:
//   FIFO_WIDTH     default data word width, matching the team FIFO
//   SKID_DEPTH     number of words the reader can hold
//   reader_state_e reader control states
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 32;
  localparam int unsigned SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } reader_state_e;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order buffer. Slot 0 is always the oldest word.
// Ports:
//   i_clk, i_rst  clock and asynchronous active-high reset
//   i_push        write i_data behind the words still held this cycle
//   i_pop         drop the head word (slot 1 moves up)
//   i_data        word to write
//   o_head        slot 0
//   o_count       occupancy, 0..2
module stream_skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_slot0;
  logic [WIDTH-1:0] r_slot1;
  logic [1:0]       r_count;

  logic [WIDTH-1:0] w_slot0_d;
  logic [WIDTH-1:0] w_slot1_d;
  logic [1:0]       w_count_d;
  logic [1:0]       w_wr_idx;

  always_comb begin
    w_slot0_d = r_slot0;
    w_slot1_d = r_slot1;
    // A pushed word lands right behind whatever survives this cycle's pop.
    w_wr_idx  = r_count - {1'b0, i_pop};
    if (i_pop) begin
      w_slot0_d = r_slot1;
    end
    if (i_push) begin
      if (w_wr_idx == 2'd0) begin
        w_slot0_d = i_data;
      end else begin
        w_slot1_d = i_data;
      end
    end
    w_count_d = r_count + {1'b0, i_push} - {1'b0, i_pop};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= 2'd0;
    end else begin
      r_slot0 <= w_slot0_d;
      r_slot1 <= w_slot1_d;
      r_count <= w_count_d;
    end
  end

  assign o_head  = r_slot0;
  assign o_count = r_count;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO. Issues FIFO reads only when
// the word (arriving one cycle later) is guaranteed a buffer slot, and
// presents buffered words on a valid/ready stream.
// Ports:
//   i_clk, i_rst    clock and asynchronous active-high reset
//   i_enable        allows new FIFO reads
//   i_fifo_empty    FIFO empty flag
//   o_fifo_rd_en    FIFO read request (combinational)
//   i_fifo_data     FIFO registered read data, valid the cycle after a read
//   o_m_valid       stream word available
//   i_m_ready       consumer accepts the word
//   o_m_data        stream word (buffer head)
//   o_busy          controller not idle
//   o_words_out     count of completed handshakes, wrapping
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  input  logic [WIDTH-1:0]     i_fifo_data,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [WIDTH-1:0]     o_m_data,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_words_out
);

  localparam logic [2:0] SKID_LIMIT = 3'(SKID_DEPTH);

  reader_state_e        r_state;
  reader_state_e        w_state_d;
  logic                 r_pend;
  logic [CNT_WIDTH-1:0] r_words;

  logic [1:0] w_cnt;
  logic [1:0] w_cnt_next;
  logic [2:0] w_occ;
  logic       w_pop;

  assign o_m_valid = (w_cnt != 2'd0);
  assign w_pop     = o_m_valid && i_m_ready;

  // Occupancy the buffer will have after this edge, ignoring a read issued now.
  assign w_occ      = {1'b0, w_cnt} + {2'b0, r_pend} - {2'b0, w_pop};
  assign w_cnt_next = w_cnt + {1'b0, r_pend} - {1'b0, w_pop};

  // Gated by reset so an asserted reset kills the request immediately.
  assign o_fifo_rd_en = !i_rst && i_enable && !i_fifo_empty && (r_state != DRAIN) &&
                        (w_occ < SKID_LIMIT);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_enable) begin
          w_state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!i_enable) begin
          w_state_d = ((w_cnt != 2'd0) || r_pend) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if ((w_cnt_next == 2'd0) && !r_pend) begin
          w_state_d = IDLE;
        end else if (i_enable) begin
          w_state_d = ACTIVE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_words <= '0;
    end else begin
      r_state <= w_state_d;
      r_pend  <= o_fifo_rd_en;
      if (w_pop) begin
        r_words <= r_words + CNT_WIDTH'(1);
      end
    end
  end

  stream_skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_pend),
    .i_pop   (w_pop),
    .i_data  (i_fifo_data),
    .o_head  (o_m_data),
    .o_count (w_cnt)
  );

  assign o_busy      = (r_state != IDLE);
  assign o_words_out = r_words;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO environment, a queue-based
// reference of the reader, and directed plus random scenarios.
module tb_fifo_stream_reader;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_DRAIN  = 2;

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic          enable     = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data  = '0;
  logic          m_valid;
  logic          m_ready    = 1'b0;
  logic [W-1:0]  m_data;
  logic          busy;
  logic [CW-1:0] words_out;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .WIDTH     (W),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd_en (fifo_rd_en),
    .i_fifo_data  (fifo_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (m_ready),
    .o_m_data     (m_data),
    .o_busy       (busy),
    .o_words_out  (words_out)
  );

  int checks = 0;
  int errors = 0;

  // Environment FIFO contents and expected delivery order.
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_order[$];

  // Reference reader: buffered words, in-flight word, state, handshake count.
  logic [W-1:0] mq[$];
  bit           m_pend;
  logic [W-1:0] m_pend_word;
  int           m_state;
  int unsigned  m_count;

  // Stimulus knobs and per-cycle DUT samples.
  bit           en_v, rdy_v, force_empty;
  bit           s_valid, s_pop, s_rd, s_busy;
  logic [W-1:0] s_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fq.push_back(w);
    exp_order.push_back(w);
  endtask

  // One clock cycle: drive at negedge, compare against the reference, then
  // advance the FIFO environment and the reference across the rising edge.
  task automatic step();
    bit           e_valid, e_pop, e_rd;
    int           occ, old_cnt;
    logic [W-1:0] w;
    @(negedge clk);
    enable     = en_v;
    m_ready    = rdy_v;
    fifo_empty = (fq.size() == 0) || force_empty;
    #1;
    e_valid = (mq.size() != 0);
    e_pop   = e_valid && rdy_v;
    occ     = mq.size() + int'(m_pend) - int'(e_pop);
    e_rd    = en_v && !fifo_empty && (m_state != M_DRAIN) && (occ < 2);
    chk("m_valid", 64'(m_valid), 64'(e_valid));
    chk("fifo_rd_en", 64'(fifo_rd_en), 64'(e_rd));
    chk("busy", 64'(busy), 64'(m_state != M_IDLE));
    chk("words_out", 64'(words_out), 64'(m_count % 16));
    if (e_valid) chk("m_data", 64'(m_data), 64'(mq[0]));
    s_valid = m_valid;
    s_pop   = m_valid && m_ready;
    s_rd    = fifo_rd_en;
    s_busy  = busy;
    s_data  = m_data;
    if (s_pop) begin
      checks++;
      if (exp_order.size() == 0) begin
        errors++;
        $display("FAIL order: got beat %0h expected no beat", m_data);
      end else begin
        w = exp_order.pop_front();
        if (m_data !== w) begin
          errors++;
          $display("FAIL order: got %0h expected %0h", m_data, w);
        end
      end
    end
    @(posedge clk);
    #1;
    old_cnt = mq.size();
    if (e_pop) begin
      void'(mq.pop_front());
      m_count++;
    end
    if (m_pend) mq.push_back(m_pend_word);
    case (m_state)
      M_IDLE:   if (en_v) m_state = M_ACTIVE;
      M_ACTIVE: if (!en_v) m_state = ((old_cnt != 0) || m_pend) ? M_DRAIN : M_IDLE;
      default: begin
        if ((mq.size() == 0) && !m_pend) m_state = M_IDLE;
        else if (en_v) m_state = M_ACTIVE;
      end
    endcase
    m_pend = e_rd;
    if (s_rd && (fq.size() != 0)) fifo_data = fq.pop_front();
    m_pend_word = fifo_data;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #3;
    rst         = 1'b1;
    enable      = 1'b0;
    en_v        = 1'b0;
    rdy_v       = 1'b0;
    force_empty = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_words_out", 64'(words_out), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    fq.delete();
    exp_order.delete();
    mq.delete();
    m_pend     = 1'b0;
    m_state    = M_IDLE;
    m_count    = 0;
    fifo_empty = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, first, last, beats, rds, busy_fall, gaps;

    do_reset();

    // Reset with one word buffered and one in flight.
    for (int i = 0; i < 8; i++) push_word(32'h200 + 32'(i));
    en_v  = 1'b1;
    rdy_v = 1'b0;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!((mq.size() == 1) && m_pend) && (guard < 10));
    chk("t1_setup_cycles", 64'(guard), 64'd2);
    do_reset();
    rdy_v = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("t1_no_stale", 64'(s_valid), 64'd0);

    // Preloaded stream, consumer always ready.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
    en_v = 1'b1; rdy_v = 1'b1;
    first = -1; last = -1; beats = 0; rds = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (s_rd) rds++;
      if (s_valid && (first < 0)) first = k;
      if (s_pop) begin beats++; last = k; end
    end
    chk("t2_first_valid", 64'(first), 64'd2);
    chk("t2_last_beat", 64'(last), 64'd9);
    chk("t2_beats", 64'(beats), 64'd8);
    chk("t2_reads", 64'(rds), 64'd8);
    chk("t2_words_out", 64'(words_out), 64'd8);

    // Backpressure: consumer stalled for 10 cycles.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
    en_v = 1'b1; rdy_v = 1'b0; rds = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_rd) rds++;
    end
    chk("t3_reads_stalled", 64'(rds), 64'd2);
    chk("t3_valid_held", 64'(s_valid), 64'd1);
    chk("t3_head_held", 64'(s_data), 64'h100);
    rdy_v = 1'b1; beats = 0; guard = 0;
    while ((beats < 8) && (guard < 30)) begin
      step();
      if (s_pop) beats++;
      guard++;
    end
    chk("t3_beats", 64'(beats), 64'd8);
    chk("t3_words_out", 64'(words_out), 64'd8);
    chk("t3_all_delivered", 64'(exp_order.size()), 64'd0);

    // FIFO empty flag toggling every cycle.
    do_reset();
    for (int i = 0; i < 6; i++) push_word(32'h300 + 32'(i));
    en_v = 1'b1; rdy_v = 1'b1; force_empty = 1'b0;
    beats = 0; rds = 0; gaps = 0; guard = 0; first = -1;
    while ((beats < 6) && (guard < 40)) begin
      force_empty = ~force_empty;
      step();
      if (s_rd) rds++;
      if (s_pop) begin beats++; if (first < 0) first = guard; end
      else if (first >= 0) gaps++;
      guard++;
    end
    force_empty = 1'b0;
    chk("t4_beats", 64'(beats), 64'd6);
    chk("t4_reads", 64'(rds), 64'd6);
    chk("t4_words_out", 64'(words_out), 64'd6);
    chk("t4_has_gaps", 64'(gaps != 0), 64'd1);

    // Enable drops with one word buffered and one in flight.
    do_reset();
    for (int i = 0; i < 10; i++) push_word(32'h400 + 32'(i));
    en_v = 1'b1; rdy_v = 1'b1; guard = 0;
    do begin
      step();
      guard++;
    end while (!((mq.size() == 1) && m_pend) && (guard < 10));
    en_v = 1'b0; beats = 0; rds = 0; last = -1; busy_fall = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (s_rd) rds++;
      if (s_pop) begin beats++; last = k; end
      if (!s_busy && (busy_fall < 0)) busy_fall = k;
    end
    chk("t5_drain_beats", 64'(beats), 64'd2);
    chk("t5_drain_reads", 64'(rds), 64'd0);
    chk("t5_busy_fall", 64'(busy_fall), 64'(last + 1));

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) push_word(32'h500 + 32'(i));
    en_v = 1'b1; rdy_v = 1'b1; beats = 0; guard = 0;
    while ((beats < 17) && (guard < 60)) begin
      step();
      if (s_pop) beats++;
      guard++;
    end
    chk("t6_beats", 64'(beats), 64'd17);
    chk("t6_wrap", 64'(words_out), 64'd1);

    // Random traffic, enable, backpressure and empty glitches.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (($urandom_range(0, 3) == 0) && (fq.size() < 16)) push_word($urandom);
      en_v        = ($urandom_range(0, 9) != 0);
      rdy_v       = ($urandom_range(0, 2) != 0);
      force_empty = ($urandom_range(0, 4) == 0);
      step();
    end
    en_v = 1'b1; rdy_v = 1'b1; force_empty = 1'b0; guard = 0;
    while (((fq.size() != 0) || (mq.size() != 0) || m_pend) && (guard < 100)) begin
      step();
      guard++;
    end
    chk("rand_all_delivered", 64'(exp_order.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the team's synchronous FIFO: drives the FIFO read enable, absorbs the FIFO's one-cycle registered read latency and presents words on a valid/ready stream.
- Sits between the FIFO read port and any downstream consumer.
- Holds at most two words, so reads are only issued when the words can be accepted.
- Sustains one word per cycle when data is available and the consumer is ready.

Parameters:
- WIDTH, 32, data word width; must match the FIFO WIDTH.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  allows new FIFO reads while high.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read request; combinational.
- fifo_data  input  WIDTH  FIFO registered output; valid the cycle after an accepted read.
- m_valid  output  1  stream word available.
- m_ready  input  1  consumer accepts the word.
- m_data  output  WIDTH  stream word; the head of the buffer.
- busy  output  1  high when state is not IDLE.
- words_out  output  CNT_WIDTH  count of completed stream handshakes; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (asynchronous, any time):
  - All outputs are 0, buffer count is 0, pend is 0, state is IDLE.
  - A read in flight when reset asserts is discarded.
  - fifo_rd_en is 0 while rst is high.
- Definitions:
  - pop = m_valid && m_ready.
  - cnt = buffer occupancy, 0..2.
  - pend = 1 when fifo_rd_en was high on the previous edge.
- Read issue: fifo_rd_en = enable && !fifo_empty && (state != DRAIN) && (cnt + pend - pop) < 2.
  - A read is only requested when the FIFO is non-empty, so every asserted fifo_rd_en is an accepted read.
- Capture: when pend=1, fifo_data is written into the buffer on that edge.
  - It goes into slot (cnt - pop), so arrival order is preserved.
  - A simultaneous pop and capture is legal; cnt is unchanged.
- Stream output:
  - m_valid = (cnt != 0).
  - m_data = slot 0.
  - Once m_valid is high, m_data is held stable until pop.
  - On pop, slot 1 shifts into slot 0.
- Latency:
  - fifo_rd_en high at edge N gives fifo_data captured at edge N+1, so m_valid is high after edge N+1.
  - Steady state (cnt=1, pend=1, pop=1) gives one read and one beat per cycle.
- Backpressure: with m_ready=0, at most 2 words are buffered plus 0 in flight; no read is issued and no data is lost.
- FSM:
  - IDLE -> ACTIVE when enable=1.
  - ACTIVE -> DRAIN when enable=0 and (cnt != 0 or pend).
  - ACTIVE -> IDLE when enable=0, cnt=0 and pend=0.
  - DRAIN -> IDLE when the next-state cnt is 0 and pend is 0; no new reads are issued in DRAIN.
  - DRAIN -> ACTIVE if enable returns high while words remain.
- Counter: words_out increments by 1 on each pop and wraps to 0.
- Boundaries:
  - fifo_empty toggling mid-stream only creates m_valid gaps.
  - enable dropping delivers all buffered and in-flight words before IDLE.

Decomposition:
- Shared package fifo_pkg:
  - Default WIDTH (32).
  - Reader state enum (IDLE, ACTIVE, DRAIN).
  - Constant SKID_DEPTH = 2.
- One sub-module, stream_skid_buf2:
  - A 2-entry in-order buffer with push/pop, count, head output.
  - Async active-high rst.
- The top level holds the FSM, the pend flag, read-issue logic and words_out.

Test Plan:
- Reset mid-stream with 1 word buffered and 1 in flight -> m_valid=0, fifo_rd_en=0, busy=0, words_out=0 immediately; no stale word appears after rst drops.
- FIFO model preloaded with 0x100..0x107, enable=1, m_ready=1 -> first m_valid after the 2nd edge, then 8 consecutive beats 0x100..0x107, words_out=8, fifo_rd_en low once empty.
- Same preload, m_ready=0 for 10 cycles -> exactly 2 reads issued, cnt=2, m_data=0x100 held stable; release m_ready -> 0x100..0x107 in order, no duplicates.
- fifo_empty forced high on alternating cycles during a 6-word stream -> m_valid gaps only; data order and words_out=6 correct.
- enable dropped with cnt=1 and pend=1 -> state DRAIN, no further fifo_rd_en, 2 more beats delivered, busy falls in the cycle after the last pop.
- CNT_WIDTH=4, 17 beats delivered -> words_out=1 (wrap).
